// File: rtl/m_load_ctrl.sv
// Memory-stage load/store sequencer: one access at a time over a req/ready + rvalid
// data-memory port, with byte enables for stores and sign-extended load results.
module m_load_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_con_req,
   input  logic        i_con_we,
   input  logic [1:0]  i_con_loadsig,
   input  logic [31:0] i_data_addr,
   input  logic [31:0] i_data_wdata,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_be,
   input  logic        i_mem_ready,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_data_Rdata,
   output logic        o_con_stall,
   output logic        o_con_done,
   output logic        o_con_err,
   output logic [31:0] o_data_Wdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        we_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic [3:0]  mem_be_q;
   logic        done_q;
   logic        err_q;
   logic [31:0] wdata_out_q;

   logic        misalign_d;
   logic [3:0]  be_d;
   logic [31:0] wrep_d;
   logic [31:0] ext_d;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Reserved size 11 is rejected together with misaligned half/word accesses.
   always_comb begin
      misalign_d = 1'b0;
      be_d       = 4'b1111;
      wrep_d     = i_data_wdata;
      case (i_con_loadsig)
         2'b10: begin
            be_d   = 4'b0001 << i_data_addr[1:0];
            wrep_d = {4{i_data_wdata[7:0]}};
         end
         2'b01: begin
            misalign_d = i_data_addr[0];
            be_d       = i_data_addr[1] ? 4'b1100 : 4'b0011;
            wrep_d     = {2{i_data_wdata[15:0]}};
         end
         2'b00:   misalign_d = (i_data_addr[1:0] != 2'b00);
         default: misalign_d = 1'b1;
      endcase
   end

   always_comb begin
      case (lane_q)
         2'd0:    byte_sel = i_data_Rdata[7:0];
         2'd1:    byte_sel = i_data_Rdata[15:8];
         2'd2:    byte_sel = i_data_Rdata[23:16];
         default: byte_sel = i_data_Rdata[31:24];
      endcase
      half_sel = lane_q[1] ? i_data_Rdata[31:16] : i_data_Rdata[15:0];
      case (size_q)
         2'b10:   ext_d = {{24{byte_sel[7]}}, byte_sel};
         2'b01:   ext_d = {{16{half_sel[15]}}, half_sel};
         default: ext_d = i_data_Rdata;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         lane_q      <= 2'd0;
         size_q      <= 2'd0;
         we_q        <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         mem_be_q    <= 4'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         wdata_out_q <= 32'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_con_req) begin
                  lane_q <= i_data_addr[1:0];
                  size_q <= i_con_loadsig;
                  we_q   <= i_con_we;
                  if (misalign_d) begin
                     state_q     <= S_DONE;
                     done_q      <= 1'b1;
                     err_q       <= 1'b1;
                     wdata_out_q <= 32'd0;
                  end else begin
                     state_q     <= S_REQ;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= i_con_we;
                     mem_addr_q  <= {i_data_addr[31:2], 2'b00};
                     mem_wdata_q <= i_con_we ? wrep_d : 32'd0;
                     mem_be_q    <= i_con_we ? be_d : 4'b1111;
                  end
               end
            end
            S_REQ: begin
               if (i_mem_ready) begin
                  state_q     <= S_WAIT;
                  cnt_q       <= 8'd0;
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= 32'd0;
                  mem_wdata_q <= 32'd0;
                  mem_be_q    <= 4'd0;
               end
            end
            S_WAIT: begin
               // rvalid takes priority over the final timeout cycle.
               if (i_mem_rvalid) begin
                  state_q     <= S_DONE;
                  done_q      <= 1'b1;
                  err_q       <= 1'b0;
                  wdata_out_q <= we_q ? 32'd0 : ext_d;
               end else if (cnt_q == LAST_CNT) begin
                  state_q     <= S_DONE;
                  done_q      <= 1'b1;
                  err_q       <= 1'b1;
                  wdata_out_q <= 32'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_con_stall  = ((state_q == S_IDLE) && i_con_req) ||
                         (state_q == S_REQ) || (state_q == S_WAIT);
   assign o_mem_req    = mem_req_q;
   assign o_mem_we     = mem_we_q;
   assign o_mem_addr   = mem_addr_q;
   assign o_mem_wdata  = mem_wdata_q;
   assign o_mem_be     = mem_be_q;
   assign o_con_done   = done_q;
   assign o_con_err    = err_q;
   assign o_data_Wdata = wdata_out_q;

endmodule

// File: tb/tb_m_load_ctrl.sv
// Bench for m_load_ctrl: transaction-level reference model checked every cycle,
// plus directed accesses with hand-computed results.
module tb_m_load_ctrl;
   localparam int unsigned TO = 4;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_con_req = 1'b0;
   logic        i_con_we = 1'b0;
   logic [1:0]  i_con_loadsig = 2'b00;
   logic [31:0] i_data_addr = 32'd0;
   logic [31:0] i_data_wdata = 32'd0;
   logic        i_mem_ready = 1'b0;
   logic        i_mem_rvalid = 1'b0;
   logic [31:0] i_data_Rdata = 32'd0;
   logic        o_mem_req, o_mem_we, o_con_stall, o_con_done, o_con_err;
   logic [31:0] o_mem_addr, o_mem_wdata, o_data_Wdata;
   logic [3:0]  o_mem_be;

   int checks = 0;
   int errors = 0;

   m_load_ctrl #(.TIMEOUT(TO)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_con_req(i_con_req), .i_con_we(i_con_we),
      .i_con_loadsig(i_con_loadsig), .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_ready(i_mem_ready),
      .i_mem_rvalid(i_mem_rvalid), .i_data_Rdata(i_data_Rdata), .o_con_stall(o_con_stall),
      .o_con_done(o_con_done), .o_con_err(o_con_err), .o_data_Wdata(o_data_Wdata)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 requesting, 2 waiting, 3 done.
   int          m_phase, m_cnt, m_nb;
   logic [31:0] m_addr, m_wd, m_out;
   logic        m_we, m_err;

   function automatic int nbytes_of(input logic [1:0] ls);
      case (ls)
         2'b10:   return 1;
         2'b01:   return 2;
         2'b00:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] low_mask(input int nb);
      return (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] rd);
      logic [31:0] v, mask;
      v = rd >> (8 * (m_addr % 4));
      mask = low_mask(m_nb);
      v = v & mask;
      if (m_nb < 4 && ((v >> (8 * m_nb - 1)) & 32'd1) != 0) v = v | ~mask;
      return v;
   endfunction

   task automatic m_reset();
      m_phase = 0; m_cnt = 0; m_nb = 4; m_addr = 0; m_wd = 0;
      m_out = 0; m_we = 0; m_err = 0;
   endtask

   task automatic m_step();
      case (m_phase)
         0: if (i_con_req) begin
            m_addr = i_data_addr; m_we = i_con_we; m_wd = i_data_wdata;
            m_nb = nbytes_of(i_con_loadsig);
            if (m_nb == 0 || (m_addr % 32'(m_nb)) != 0) begin
               m_phase = 3; m_err = 1; m_out = 0;
            end else m_phase = 1;
         end
         1: if (i_mem_ready) begin m_phase = 2; m_cnt = 0; end
         2: if (i_mem_rvalid) begin
               m_phase = 3; m_err = 0; m_out = m_we ? 32'd0 : extract(i_data_Rdata);
            end else if (m_cnt == int'(TO) - 1) begin
               m_phase = 3; m_err = 1; m_out = 0;
            end else m_cnt++;
         default: m_phase = 0;
      endcase
   endtask

   task automatic compare();
      logic        inreq;
      logic [31:0] be, rep;
      inreq = (m_phase == 1);
      be  = ((32'd1 << m_nb) - 32'd1) << (m_addr % 4);
      rep = (m_wd & low_mask(m_nb)) * ((m_nb == 1) ? 32'h0101_0101 :
                                       (m_nb == 2) ? 32'h0001_0001 : 32'd1);
      chk("mem_req", 32'(o_mem_req), 32'(inreq));
      chk("mem_we", 32'(o_mem_we), 32'(inreq && m_we));
      chk("mem_addr", o_mem_addr, inreq ? (m_addr & ~32'd3) : 32'd0);
      chk("mem_be", 32'(o_mem_be), inreq ? (m_we ? (be & 32'hF) : 32'hF) : 32'd0);
      if (!inreq || m_we) chk("mem_wdata", o_mem_wdata, inreq ? rep : 32'd0);
      chk("stall", 32'(o_con_stall),
          32'((m_phase == 0 && i_con_req) || m_phase == 1 || m_phase == 2));
      chk("done", 32'(o_con_done), 32'(m_phase == 3));
      chk("err", 32'(o_con_err), 32'(m_err));
      chk("Wdata", o_data_Wdata, m_out);
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge i_clk);
         if (i_rst) m_reset(); else m_step();
         @(negedge i_clk);
         if (i_rst) m_reset();
         compare();
      end
   end

   // One access; ready rises rdly cycles into REQ, rvalid pulses vdly cycles into
   // WAIT (never if negative); noise holds rvalid high during REQ.
   task automatic run(input string nm, input logic we, input logic [1:0] ls,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                      input int rdly, input int vdly, input logic noise,
                      input int exp_cyc, input logic [31:0] exp_out, input logic exp_err,
                      input logic [31:0] exp_maddr, input logic [3:0] exp_be,
                      input logic [31:0] exp_mwd, input int exp_reqcyc);
      int done_cyc = -1;
      int req_cyc = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         i_con_req    = (cyc == 0);
         i_con_we     = we; i_con_loadsig = ls; i_data_addr = addr; i_data_wdata = wd;
         i_mem_ready  = (cyc >= 1 + rdly);
         i_mem_rvalid = (vdly >= 0 && cyc == 2 + rdly + vdly) ||
                        (noise && cyc >= 1 && cyc < 2 + rdly);
         i_data_Rdata = rd;
         @(negedge i_clk);
         if (o_mem_req) begin
            if (req_cyc == 0) begin
               chk({nm, " mem_addr"}, o_mem_addr, exp_maddr);
               chk({nm, " mem_be"}, 32'(o_mem_be), 32'(exp_be));
               if (we) chk({nm, " mem_wdata"}, o_mem_wdata, exp_mwd);
            end
            req_cyc++;
         end
         if (o_con_done) begin
            done_cyc = cyc;
            break;
         end
         @(posedge i_clk); #1;
      end
      chk({nm, " done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
      chk({nm, " req_cycles"}, 32'(req_cyc), 32'(exp_reqcyc));
      chk({nm, " Wdata"}, o_data_Wdata, exp_out);
      chk({nm, " err"}, 32'(o_con_err), 32'(exp_err));
      $display("txn %s: done@%0d Wdata=%h err=%0b", nm, done_cyc, o_data_Wdata, o_con_err);
      @(posedge i_clk); #1;
      i_con_req = 0; i_mem_ready = 0; i_mem_rvalid = 0;
      @(posedge i_clk); #1;
   endtask

   initial begin
      #2;
      chk("reset Wdata", o_data_Wdata, 32'd0);
      chk("reset mem_be", 32'(o_mem_be), 32'd0);
      chk("reset done", 32'(o_con_done), 32'd0);
      @(posedge i_clk); #1;
      i_rst = 0;
      @(posedge i_clk); #1;

      run("ld_byte", 0, 2'b10, 32'h103, 0, 32'h8012_3456, 0, 0, 0,
          3, 32'hFFFF_FF80, 0, 32'h100, 4'hF, 0, 1);
      run("misalign_word", 0, 2'b00, 32'h6, 0, 32'hDEAD_BEEF, 0, 0, 0,
          1, 32'd0, 1, 0, 0, 0, 0);
      run("ld_byte_pos", 0, 2'b10, 32'h101, 0, 32'h0000_7F00, 0, 0, 0,
          3, 32'h0000_007F, 0, 32'h100, 4'hF, 0, 1);
      run("reserved_ls", 0, 2'b11, 32'h8, 0, 32'h1111_1111, 0, 0, 0,
          1, 32'd0, 1, 0, 0, 0, 0);
      run("ld_half_pos", 0, 2'b01, 32'h22, 0, 32'h7FFF_8000, 0, 0, 0,
          3, 32'h0000_7FFF, 0, 32'h20, 4'hF, 0, 1);
      run("ld_half_neg", 0, 2'b01, 32'h22, 0, 32'h8001_1234, 0, 0, 0,
          3, 32'hFFFF_8001, 0, 32'h20, 4'hF, 0, 1);
      run("st_byte", 1, 2'b10, 32'h41, 32'h0000_00AB, 0, 3, 0, 1,
          6, 32'd0, 0, 32'h40, 4'b0010, 32'hABAB_ABAB, 4);
      run("st_half", 1, 2'b01, 32'h12, 32'h1234_CDEF, 0, 0, 1, 0,
          4, 32'd0, 0, 32'h10, 4'b1100, 32'hCDEF_CDEF, 1);
      run("ld_word_late", 0, 2'b00, 32'h200, 0, 32'h1234_5678, 0, 3, 0,
          6, 32'h1234_5678, 0, 32'h200, 4'hF, 0, 1);
      run("timeout", 0, 2'b00, 32'h204, 0, 32'hFFFF_FFFF, 0, -1, 0,
          6, 32'd0, 1, 32'h204, 4'hF, 0, 1);
      run("ld_half_low", 0, 2'b01, 32'h300, 0, 32'h5555_9ABC, 1, 1, 0,
          5, 32'hFFFF_9ABC, 0, 32'h300, 4'hF, 0, 2);

      // Reset during WAIT, then a stray rvalid in IDLE.
      i_con_req = 1; i_con_we = 0; i_con_loadsig = 2'b00; i_data_addr = 32'h300;
      i_mem_ready = 1; i_data_Rdata = 32'h0BAD_F00D;
      @(posedge i_clk); #1;
      i_con_req = 0;
      @(posedge i_clk); #3;
      chk("pre-reset stall", 32'(o_con_stall), 32'd1);
      i_rst = 1; i_mem_ready = 0;
      #1;
      chk("rst Wdata", o_data_Wdata, 32'd0);
      chk("rst err", 32'(o_con_err), 32'd0);
      chk("rst stall", 32'(o_con_stall), 32'd0);
      chk("rst mem_be", 32'(o_mem_be), 32'd0);
      @(posedge i_clk); #1;
      i_rst = 0; i_mem_rvalid = 1;
      @(negedge i_clk);
      chk("stray rvalid done", 32'(o_con_done), 32'd0);
      @(posedge i_clk); #1;
      i_mem_rvalid = 0;
      @(negedge i_clk);
      chk("stray rvalid done2", 32'(o_con_done), 32'd0);
      @(posedge i_clk); #1;
      $display("txn reset_in_wait: outputs cleared, no done");

      run("after_reset", 0, 2'b10, 32'h102, 0, 32'h00C3_0000, 0, 0, 0,
          3, 32'hFFFF_FFC3, 0, 32'h100, 4'hF, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/m_load_ctrl.md
# m_load_ctrl

Memory-stage load/store sequencer for the pipelined core. It accepts one access at a time from the pipeline and drives a single data-memory port with a request/ready handshake. It waits for the response and extracts and sign-extends the loaded byte, half or word into the write-back value. It also generates byte enables for stores and stalls the pipeline until the access completes, errors or times out.

## Interface
Parameters:
- TIMEOUT, 15: maximum WAIT cycles before the access is abandoned with error (1..255).

Ports:
- i_clk  in  1  single clock; all state changes on rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_con_req  in  1  pipeline access request; sampled only in IDLE.
- i_con_we  in  1  1 = store, 0 = load.
- i_con_loadsig  in  2  size: 00 word, 10 byte, 01 half, 11 reserved.
- i_data_addr  in  32  byte address.
- i_data_wdata  in  32  store data (low bytes significant for byte/half).
- o_mem_req  out  1  memory request valid.
- o_mem_we  out  1  memory write strobe.
- o_mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- o_mem_wdata  out  32  store data, lane-replicated.
- o_mem_be  out  4  byte enables.
- i_mem_ready  in  1  memory accepts request this cycle.
- i_mem_rvalid  in  1  response/ack valid (loads and stores).
- i_data_Rdata  in  32  memory read word.
- o_con_stall  out  1  hold pipeline.
- o_con_done  out  1  one-cycle completion pulse.
- o_con_err  out  1  misalign or timeout; valid with o_con_done.
- o_data_Wdata  out  32  extended load result.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on i_con_req=1, latch addr, we, wdata, loadsig.
  - If misaligned (half with addr[0]=1; word with addr[1:0]!=0), go to DONE with err=1 and Wdata=0. No memory request is issued.
  - Reserved loadsig 11 is treated the same as misaligned.
  - Otherwise go to REQ.
- REQ: o_mem_req=1; o_mem_we, addr, wdata and be are driven from the latched values. Stay in REQ until i_mem_ready=1, then go to WAIT.
- WAIT: count cycles from 0.
  - On i_mem_rvalid=1, go to DONE with err=0. A load captures its extended result; a store sets Wdata=0.
  - If the count reaches TIMEOUT-1 without rvalid, go to DONE with err=1 and Wdata=0.
  - If rvalid arrives in the same cycle the count hits TIMEOUT-1, rvalid wins and the access succeeds.
- DONE: o_con_done=1 for exactly one cycle, then unconditionally return to IDLE. i_con_req is not sampled in DONE.
- Load extraction, with lane = addr[1:0]:
  - byte = Rdata[8*lane+:8], sign-extended from bit 7.
  - half = Rdata[16*addr[1]+:16], sign-extended from bit 15.
  - word = Rdata unchanged.
- Store byte enables:
  - byte: 4'b0001<<lane, wdata[7:0] replicated ×4.
  - half: 4'b0011<<(2*addr[1]), wdata[15:0] replicated ×2.
  - word: 4'b1111.
- Loads drive o_mem_be=4'b1111 and o_mem_we=0.
- Stall: o_con_stall = (IDLE & i_con_req) | REQ | WAIT. It is low in DONE.
- i_mem_ready and i_mem_rvalid are ignored outside REQ and WAIT respectively. rvalid seen in REQ is not a completion.

## Timing
- Reset (async): state IDLE, counter 0, latched fields 0. All outputs 0: o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_con_done, o_con_err, o_data_Wdata.
- Reset asserted mid-access abandons the access. A late rvalid after reset arrives in IDLE and is ignored.
- Minimum latency, with ready and rvalid each asserted immediately:
  - cycle 0: IDLE sees req.
  - cycle 1: REQ.
  - cycle 2: WAIT.
  - cycle 3: DONE.
- Misaligned access: req in cycle 0, DONE in cycle 1.
- o_data_Wdata and o_con_err are registered. They update on entry to DONE and hold until the next DONE.
- Memory port outputs are registered and stable throughout REQ. They return to 0 outside REQ.

## Test plan
- Load byte, addr=0x103, Rdata=0x80_12_34_56, immediate ready/rvalid -> DONE at cycle 3, Wdata=0xFFFFFF80, err=0, o_mem_addr=0x100.
- Load half, addr=0x22, Rdata=0x7FFF_8000 -> Wdata=0x00007FFF. Same with Rdata=0x8001_1234 -> Wdata=0xFFFF8001.
- Store byte, addr=0x41, wdata=0xAB -> o_mem_be=4'b0010, o_mem_wdata=0xABABABAB, o_mem_we=1. Ready held low for 3 cycles: REQ lasts 4 cycles with stall=1, then done with Wdata=0.
- Misaligned word load at addr=0x6 -> no o_mem_req ever asserted, DONE in cycle 1 with err=1 and Wdata=0. Repeat with loadsig=11.
- Timeout with TIMEOUT=4, rvalid never asserted -> 4 WAIT cycles, then done with err=1. Also, rvalid on the 4th WAIT cycle -> success with err=0.
- Reset asserted during WAIT, then rvalid pulsed in IDLE -> all outputs 0 immediately, no done pulse, next request proceeds normally.
